// File: rtl/ram_rmw_ctrl_if.sv
// Command/response bundle for ram_rmw_ctrl: valid/ready command in, read data and status out.
interface ram_rmw_ctrl_if #(
   parameter int unsigned DW  = 16,
   parameter int unsigned ADW = 4
);
   logic           cmd_valid;
   logic           cmd_ready;
   logic [1:0]     cmd;
   logic [ADW-1:0] addr;
   logic [DW-1:0]  din;
   logic [DW-1:0]  dout;
   logic           dout_valid;
   logic           dout_ovf;
   logic           init_busy;

   modport master (
      output cmd_valid, cmd, addr, din,
      input  cmd_ready, dout, dout_valid, dout_ovf, init_busy
   );

   modport slave (
      input  cmd_valid, cmd, addr, din,
      output cmd_ready, dout, dout_valid, dout_ovf, init_busy
   );
endinterface

// File: rtl/ram_rmw_ctrl.sv
// Single-port RAM with write, read and atomic fetch-and-add, a configurable read pipeline
// and a post-reset clear sweep.
module ram_rmw_ctrl #(
   parameter int unsigned DW     = 16,
   parameter int unsigned ADW    = 4,
   parameter int unsigned RD_LAT = 1
) (
   input logic           clk,
   input logic           rst_n,
   ram_rmw_ctrl_if.slave bus
);

   localparam int unsigned DEPTH = 2 ** ADW;

   localparam logic [1:0] ST_INIT   = 2'd0;
   localparam logic [1:0] ST_IDLE   = 2'd1;
   localparam logic [1:0] ST_RMW_WR = 2'd2;

   localparam logic [1:0] CMD_WR  = 2'b10;
   localparam logic [1:0] CMD_RD  = 2'b01;
   localparam logic [1:0] CMD_RMW = 2'b11;

   logic [1:0]        r_state;
   logic [ADW-1:0]    r_cnt;
   logic [ADW-1:0]    r_addr;
   logic [DW-1:0]     r_old;
   logic [DW-1:0]     r_din;
   logic [DW-1:0]     r_mem [DEPTH];

   logic [RD_LAT-1:0] r_pv;
   logic [RD_LAT-1:0] r_po;
   logic [DW-1:0]     r_pd [RD_LAT];

   logic              w_ready;
   logic              w_accept;
   logic              w_wr;
   logic              w_rd;
   logic              w_rmw;
   logic [DW:0]       w_sum;
   logic              w_st1_v;
   logic [DW-1:0]     w_st1_d;
   logic              w_st1_o;

   assign w_ready  = (r_state == ST_IDLE);
   assign w_accept = bus.cmd_valid & w_ready;
   assign w_wr     = w_accept & (bus.cmd == CMD_WR);
   assign w_rd     = w_accept & (bus.cmd == CMD_RD);
   assign w_rmw    = w_accept & (bus.cmd == CMD_RMW);
   assign w_sum    = {1'b0, r_old} + {1'b0, r_din};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_old   <= '0;
         r_din   <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (&r_cnt) r_state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (w_rmw) begin
                  r_old   <= r_mem[bus.addr];
                  r_addr  <= bus.addr;
                  r_din   <= bus.din;
                  r_state <= ST_RMW_WR;
               end
            end
            ST_RMW_WR: r_state <= ST_IDLE;
            default:   r_state <= ST_INIT;
         endcase
      end
   end

   // Storage has no reset; the async state reset forces INIT so a pending RMW never writes back.
   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr) begin
         r_mem[bus.addr] <= bus.din;
      end else if (r_state == ST_RMW_WR) begin
         r_mem[r_addr] <= w_sum[DW-1:0];
      end
   end

   always_comb begin
      w_st1_v = 1'b0;
      w_st1_d = '0;
      w_st1_o = 1'b0;
      if (w_rd) begin
         w_st1_v = 1'b1;
         w_st1_d = r_mem[bus.addr];
      end else if (r_state == ST_RMW_WR) begin
         w_st1_v = 1'b1;
         w_st1_d = r_old;
         w_st1_o = w_sum[DW];
      end
   end

   // Data only moves with a valid token so the output stage holds its last result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pv <= '0;
         r_po <= '0;
         for (int i = 0; i < RD_LAT; i++) r_pd[i] <= '0;
      end else begin
         r_pv[0] <= w_st1_v;
         if (w_st1_v) begin
            r_pd[0] <= w_st1_d;
            r_po[0] <= w_st1_o;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            if (r_pv[i-1]) begin
               r_pd[i] <= r_pd[i-1];
               r_po[i] <= r_po[i-1];
            end
         end
      end
   end

   assign bus.cmd_ready  = w_ready;
   assign bus.init_busy  = (r_state == ST_INIT);
   assign bus.dout       = r_pd[RD_LAT-1];
   assign bus.dout_valid = r_pv[RD_LAT-1];
   assign bus.dout_ovf   = r_po[RD_LAT-1];

endmodule
